huffman_decoder: RTL

- Receive-side counterpart of the huffman encoder.
- Loads the six-entry code table (HC1..HC6, M1..M6) that the encoder emits with code_valid.
- Consumes a serial MSB-first code bitstream and emits one decoded gray symbol (1..6) per complete codeword.
- Sits after the encoder in the image path; output is a registered valid/ready stream.

---
 rtl/huffman_decoder_pkg.sv | 36 +++
 rtl/huffman_decoder_match.sv | 34 +++
 rtl/huffman_decoder.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/huffman_decoder_pkg.sv
// Shared definitions for the Huffman decoder: FSM encoding, table geometry
// and the mask helper functions used when a code table is loaded.
package huffman_pkg;

    // Decoder states: no table yet, decoding, or halted on a fault
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_ERROR  = 2'd2
    } state_e;

    localparam int NSYM   = 6;   // number of table entries / symbols
    localparam int CODE_W = 8;   // codeword and mask width
    localparam int LEN_W  = 4;   // width of a code length (popcount of a mask)
    localparam int IDX_W  = 3;   // symbol index 1..6

    // Number of ones in an 8-bit mask, i.e. the code length it describes
    function automatic logic [LEN_W-1:0] popcount8(input logic [CODE_W-1:0] v);
        logic [LEN_W-1:0] c;
        c = 4'd0;
        for (int k = 0; k < CODE_W; k++) begin
            c = c + {3'b000, v[k]};
        end
        return c;
    endfunction

    // A usable mask is nonzero, a run of low-order ones, and not longer
    // than the shift register can hold
    function automatic logic mask_ok(input logic [CODE_W-1:0] m,
                                     input logic [LEN_W-1:0]  max_len);
        return (m != 8'h00) &&
               ((m & (m + 8'h01)) == 8'h00) &&
               (popcount8(m) <= max_len);
    endfunction

endpackage

// File: rtl/huffman_decoder_match.sv
// Combinational codeword matcher: compares the candidate shift value and
// length against all six table entries; the lowest-numbered hit wins.
module huffman_match
    import huffman_pkg::*;
(
    input  logic [CODE_W-1:0]           nshift_i,
    input  logic [LEN_W-1:0]            nlen_i,
    input  logic [NSYM-1:0][CODE_W-1:0] hc_i,
    input  logic [NSYM-1:0][CODE_W-1:0] m_i,
    output logic                        hit_o,
    output logic [IDX_W-1:0]            idx_o
);

    logic [NSYM-1:0] match_s;

    // Per-entry match: length equal to the mask popcount and masked bits equal
    always_comb begin
        match_s = '0;
        for (int k = 0; k < NSYM; k++) begin
            match_s[k] = (nlen_i == popcount8(m_i[k])) &&
                         ((nshift_i & m_i[k]) == hc_i[k]);
        end
    end

    // Priority pick: scan from the highest entry down so the lowest survives
    always_comb begin
        hit_o = |match_s;
        idx_o = 3'd0;
        for (int k = NSYM - 1; k >= 0; k--) begin
            idx_o = match_s[k] ? IDX_W'(k + 1) : idx_o;
        end
    end

endmodule

// File: rtl/huffman_decoder.sv
// Huffman decoder top: loads a six-entry code table, shifts in a serial
// MSB-first bitstream and emits one symbol (1..6) per complete codeword on a
// registered valid/ready output.
// Optional per-symbol decode counters are built when HUFFDEC_CNT_EN is defined;
// otherwise dec_cnt1..dec_cnt6 are constant zero.
module huffman_decoder
    import huffman_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int SYM_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             code_valid,
    input  logic [7:0]       HC1,
    input  logic [7:0]       HC2,
    input  logic [7:0]       HC3,
    input  logic [7:0]       HC4,
    input  logic [7:0]       HC5,
    input  logic [7:0]       HC6,
    input  logic [7:0]       M1,
    input  logic [7:0]       M2,
    input  logic [7:0]       M3,
    input  logic [7:0]       M4,
    input  logic [7:0]       M5,
    input  logic [7:0]       M6,
    input  logic             bit_valid,
    input  logic             bit_in,
    output logic             bit_ready,
    output logic             sym_valid,
    output logic [SYM_W-1:0] sym_data,
    input  logic             sym_ready,
    output logic             dec_err,
    output logic [7:0]       dec_cnt1,
    output logic [7:0]       dec_cnt2,
    output logic [7:0]       dec_cnt3,
    output logic [7:0]       dec_cnt4,
    output logic [7:0]       dec_cnt5,
    output logic [7:0]       dec_cnt6
);

    localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);

    logic [NSYM-1:0][CODE_W-1:0] hc_in_s;
    logic [NSYM-1:0][CODE_W-1:0] m_in_s;

    state_e                      state_q,     state_d;
    logic [MAX_LEN-1:0]          shift_q,     shift_d;
    logic [LEN_W-1:0]            len_q,       len_d;
    logic [NSYM-1:0][CODE_W-1:0] hc_q,        hc_d;
    logic [NSYM-1:0][CODE_W-1:0] m_q,         m_d;
    logic                        sym_valid_q, sym_valid_d;
    logic [SYM_W-1:0]            sym_data_q,  sym_data_d;
    logic                        dec_err_q,   dec_err_d;

    logic [MAX_LEN-1:0]          nshift_s;
    logic [LEN_W-1:0]            nlen_s;
    logic                        table_ok_s;
    logic                        bit_ready_s;
    logic                        bit_acc_s;
    logic                        hit_s;
    logic [IDX_W-1:0]            idx_s;

    assign hc_in_s = {HC6, HC5, HC4, HC3, HC2, HC1};
    assign m_in_s  = {M6, M5, M4, M3, M2, M1};

    // Candidate register contents if the offered bit is taken this cycle
    assign nshift_s = (shift_q << 1) | MAX_LEN'(bit_in);
    assign nlen_s   = len_q + 4'd1;

    // A load only leads to DECODE when every incoming mask is usable
    always_comb begin
        table_ok_s = 1'b1;
        for (int k = 0; k < NSYM; k++) begin
            table_ok_s = table_ok_s & mask_ok(m_in_s[k], MAX_LEN_C);
        end
    end

    // Accept bits only while decoding with room in the output slot; a
    // table load in the same cycle takes priority over the bit
    assign bit_ready_s = (state_q == ST_DECODE) &&
                         (!sym_valid_q || sym_ready) && !code_valid;
    assign bit_acc_s   = bit_valid && bit_ready_s;

    huffman_match u_match (
        .nshift_i (CODE_W'(nshift_s)),
        .nlen_i   (nlen_s),
        .hc_i     (hc_q),
        .m_i      (m_q),
        .hit_o    (hit_s),
        .idx_o    (idx_s)
    );

    // Next-state logic: table load, output pop, bit shift, match and overflow
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        len_d       = len_q;
        hc_d        = hc_q;
        m_d         = m_q;
        sym_valid_d = sym_valid_q;
        sym_data_d  = sym_data_q;
        dec_err_d   = dec_err_q;

        if (code_valid) begin
            hc_d        = hc_in_s;
            m_d         = m_in_s;
            shift_d     = '0;
            len_d       = 4'd0;
            sym_valid_d = 1'b0;
            dec_err_d   = !table_ok_s;
            state_d     = table_ok_s ? ST_DECODE : ST_ERROR;
        end else begin
            sym_valid_d = (sym_valid_q && sym_ready) ? 1'b0 : sym_valid_q;
            if (bit_acc_s) begin
                if (hit_s) begin
                    sym_valid_d = 1'b1;
                    sym_data_d  = SYM_W'(idx_s);
                    shift_d     = '0;
                    len_d       = 4'd0;
                end else if (nlen_s < MAX_LEN_C) begin
                    shift_d = nshift_s;
                    len_d   = nlen_s;
                end else begin
                    state_d   = ST_ERROR;
                    dec_err_d = 1'b1;
                    shift_d   = '0;
                    len_d     = 4'd0;
                end
            end else begin
                state_d = state_q;
            end
        end
    end

    // State, table and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            len_q       <= 4'd0;
            hc_q        <= '0;
            m_q         <= '0;
            sym_valid_q <= 1'b0;
            sym_data_q  <= '0;
            dec_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            len_q       <= len_d;
            hc_q        <= hc_d;
            m_q         <= m_d;
            sym_valid_q <= sym_valid_d;
            sym_data_q  <= sym_data_d;
            dec_err_q   <= dec_err_d;
        end
    end

    assign bit_ready = bit_ready_s;
    assign sym_valid = sym_valid_q;
    assign sym_data  = sym_data_q;
    assign dec_err   = dec_err_q;

`ifdef HUFFDEC_CNT_EN
    logic [NSYM-1:0][7:0] cnt_q, cnt_d;
    logic                 sym_load_s;

    assign sym_load_s = bit_acc_s && hit_s;

    // Saturating tally of each symbol as it enters the output register
    always_comb begin
        cnt_d = cnt_q;
        if (code_valid) begin
            cnt_d = '0;
        end else if (sym_load_s) begin
            for (int k = 0; k < NSYM; k++) begin
                cnt_d[k] = ((idx_s == IDX_W'(k + 1)) && (cnt_q[k] != 8'hFF)) ?
                           cnt_q[k] + 8'd1 : cnt_q[k];
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign dec_cnt1 = cnt_q[0];
    assign dec_cnt2 = cnt_q[1];
    assign dec_cnt3 = cnt_q[2];
    assign dec_cnt4 = cnt_q[3];
    assign dec_cnt5 = cnt_q[4];
    assign dec_cnt6 = cnt_q[5];
`else
    assign dec_cnt1 = 8'h00;
    assign dec_cnt2 = 8'h00;
    assign dec_cnt3 = 8'h00;
    assign dec_cnt4 = 8'h00;
    assign dec_cnt5 = 8'h00;
    assign dec_cnt6 = 8'h00;
`endif

endmodule
